// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - 3-wire serial word receiver with valid/ready output, frame-error/overrun flags and counters
module serial_word_rx #(
  parameter int DW   = 16,
  parameter int CNTW = 16
) (
  input  logic            aclk,
  input  logic            areset,
  input  logic            en,
  input  logic            sclk,
  input  logic            sdi,
  input  logic            cs_n,
  output logic [DW-1:0]   m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            frame_err,
  output logic            overrun,
  output logic [CNTW-1:0] frame_cnt,
  output logic [CNTW-1:0] err_cnt
);

  localparam int BW = $clog2(DW + 2);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;
  localparam logic [BW-1:0] BIT_FULL = BW'(DW);
  localparam logic [BW-1:0] BIT_SAT  = BW'(DW + 1);
  localparam logic [CNTW-1:0] CNT_MAX = '1;

  // Index 0/1 are the synchroniser stages, index 2 is the edge-detect history.
  logic [2:0]      sclk_sync_q, sclk_sync_d;
  logic [2:0]      cs_sync_q, cs_sync_d;
  logic [1:0]      sdi_sync_q, sdi_sync_d;
  logic [0:0]      state_q, state_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]   shreg_q, shreg_d;
  logic [DW-1:0]   m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic [CNTW-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNTW-1:0] err_cnt_q, err_cnt_d;

  logic            sclk_rise, cs_rise, cs_fall;
  logic [BW-1:0]   cnt_next;
  logic [DW-1:0]   shreg_next;

  assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
  assign cs_rise   = cs_sync_q[1] & ~cs_sync_q[2];
  assign cs_fall   = ~cs_sync_q[1] & cs_sync_q[2];

  always_comb begin
    sclk_sync_d = {sclk_sync_q[1:0], sclk};
    cs_sync_d   = {cs_sync_q[1:0], cs_n};
    sdi_sync_d  = {sdi_sync_q[0], sdi};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q & ~m_ready;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    cnt_next    = bit_cnt_q;
    shreg_next  = shreg_q;

    if (sclk_rise) begin
      shreg_next = {shreg_q[DW-2:0], sdi_sync_q[1]};
      cnt_next   = (bit_cnt_q == BIT_SAT) ? bit_cnt_q : bit_cnt_q + BW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cs_fall && en) begin
          state_d   = ST_SHIFT;
          bit_cnt_d = '0;
          shreg_d   = '0;
        end
      end
      default: begin
        if (!en) begin
          state_d = ST_IDLE;
        end else begin
          // A bit arriving together with the close is counted before judging the frame.
          bit_cnt_d = cnt_next;
          shreg_d   = shreg_next;
          if (cs_rise) begin
            state_d = ST_IDLE;
            if (cnt_next != BIT_FULL) begin
              frame_err_d = 1'b1;
            end else if (m_valid_q && !m_ready) begin
              overrun_d = 1'b1;
            end else begin
              m_data_d  = shreg_next;
              m_valid_d = 1'b1;
              if (frame_cnt_q != CNT_MAX) frame_cnt_d = frame_cnt_q + CNTW'(1);
            end
            if ((frame_err_d || overrun_d) && err_cnt_q != CNT_MAX) begin
              err_cnt_d = err_cnt_q + CNTW'(1);
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      sclk_sync_q <= 3'b111;
      cs_sync_q   <= 3'b000;
      sdi_sync_q  <= 2'b00;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
